// File: rtl/throttle_pkg.sv
// Shared types and default sizing for the rate throttle block.
// THROTTLE_STEP_EN (see rate_throttle) decides whether the PAUSE state is ever reachable.
package throttle_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    PAUSE = 1'b1
  } state_t;

  localparam int NUM_RATES_DEF = 6;
  localparam int BASE_LOG2_DEF = 26;
  localparam int DB_W_DEF      = 16;

  // Width of the rate index; never below one bit.
  function automatic int rate_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rate_throttle_if.sv
// Button inputs and slow-clock/tick outputs of rate_throttle; master drives buttons, slave is the throttle.
// Pause/step pins exist in every build; THROTTLE_STEP_EN decides whether the throttle listens to them.
interface rate_throttle_if #(
  parameter int NUM_RATES = throttle_pkg::NUM_RATES_DEF
);
  localparam int RATE_W = throttle_pkg::rate_w(NUM_RATES);

  logic              pb_freq_up;
  logic              pb_freq_dn;
  logic              pb_pause;
  logic              pb_step;
  logic              slow_clk;
  logic              tick;
  logic [RATE_W-1:0] freq_num;
  logic              paused;

  modport master (
    output pb_freq_up, pb_freq_dn, pb_pause, pb_step,
    input  slow_clk, tick, freq_num, paused
  );

  modport slave (
    input  pb_freq_up, pb_freq_dn, pb_pause, pb_step,
    output slow_clk, tick, freq_num, paused
  );

endinterface

// File: rtl/pb_debounce.sv
// Active-low push-button cleaner: 2-flop synchroniser, then a level accepted after 2^DB_W stable cycles.
// press pulses for one cycle, aligned with the debounced level falling; no backpressure.
module pb_debounce #(
  parameter int DB_W = 16
) (
  input  logic CLK_50,
  input  logic reset,
  input  logic pb_n,
  output logic level,
  output logic press
);
  logic            sync1;
  logic            sync2;
  logic [DB_W-1:0] cnt;

  // cnt runs only while the synchronised input disagrees with level; any agreement restarts it.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= pb_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (&cnt) begin
        level <= sync2;
        press <= ~sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/rate_throttle.sv
// Button-selected power-of-two slow clock plus tick; registered outputs, rate moves 1 cycle after a press pulse; no backpressure.
// Define THROTTLE_STEP_EN to build the pause/single-step controls; otherwise the block always runs.
module rate_throttle
  import throttle_pkg::*;
#(
  parameter int NUM_RATES  = NUM_RATES_DEF,
  parameter int BASE_LOG2  = BASE_LOG2_DEF,
  parameter int RESET_RATE = 0,
  parameter int DB_W       = DB_W_DEF
) (
  input  logic           CLK_50,
  input  logic           reset,
  rate_throttle_if.slave bus
);
  localparam int RATE_W = rate_w(NUM_RATES);
  localparam int IDX_W  = $clog2(BASE_LOG2);
  localparam logic [RATE_W-1:0] MAX_RATE = RATE_W'(NUM_RATES - 1);
  localparam logic [RATE_W-1:0] RST_RATE = RATE_W'(RESET_RATE);
  localparam logic [IDX_W-1:0]  TOP_IDX  = IDX_W'(BASE_LOG2 - 1);

  state_t               state;
  logic                 run;
  logic                 up_p;
  logic                 dn_p;
  logic                 step_tick;
  logic                 unused_up_lvl;
  logic                 unused_dn_lvl;
  logic [BASE_LOG2-1:0] cnt;
  logic [RATE_W-1:0]    freq_num;
  logic [RATE_W-1:0]    freq_nxt;
  logic [IDX_W-1:0]     bit_idx;
  logic                 sel_bit;
  logic                 freq_chg;
  logic                 resync;
  logic                 slow_clk;
  logic                 tick;

  pb_debounce #(.DB_W(DB_W)) u_db_up (
    .CLK_50(CLK_50), .reset(reset), .pb_n(bus.pb_freq_up), .level(unused_up_lvl), .press(up_p)
  );
  pb_debounce #(.DB_W(DB_W)) u_db_dn (
    .CLK_50(CLK_50), .reset(reset), .pb_n(bus.pb_freq_dn), .level(unused_dn_lvl), .press(dn_p)
  );

`ifdef THROTTLE_STEP_EN
  state_t state_nxt;
  logic   pause_p;
  logic   step_p;
  logic   unused_pause_lvl;
  logic   unused_step_lvl;

  pb_debounce #(.DB_W(DB_W)) u_db_pause (
    .CLK_50(CLK_50), .reset(reset), .pb_n(bus.pb_pause), .level(unused_pause_lvl), .press(pause_p)
  );
  pb_debounce #(.DB_W(DB_W)) u_db_step (
    .CLK_50(CLK_50), .reset(reset), .pb_n(bus.pb_step), .level(unused_step_lvl), .press(step_p)
  );

  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (pause_p) state_nxt = (state == RUN) ? PAUSE : RUN;
  end

  // A coinciding pause press wins; the step is dropped.
  assign step_tick = (state == PAUSE) && step_p && !pause_p;
`else
  logic unused_pb;
  assign unused_pb = bus.pb_pause ^ bus.pb_step;
  assign state     = RUN;
  assign step_tick = 1'b0;
`endif

  always_comb begin
    freq_nxt = freq_num;
    if (up_p && !dn_p && (freq_num != MAX_RATE))
      freq_nxt = freq_num + 1'b1;
    else if (dn_p && !up_p && (freq_num != '0))
      freq_nxt = freq_num - 1'b1;
  end

  assign run      = (state == RUN);
  assign freq_chg = (freq_nxt != freq_num);
  assign bit_idx  = TOP_IDX - IDX_W'(freq_num);
  assign sel_bit  = cnt[bit_idx];

  // After a rate change slow_clk still holds a bit from the old rate; resync keeps the
  // first reload under the new rate (possibly after a pause) from looking like a rising edge.
  always_ff @(posedge CLK_50 or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      slow_clk <= 1'b0;
      tick     <= 1'b0;
      freq_num <= RST_RATE;
      resync   <= 1'b0;
    end else begin
      freq_num <= freq_nxt;
      if (run) begin
        cnt      <= cnt + 1'b1;
        slow_clk <= sel_bit;
      end
      if (freq_chg)  resync <= 1'b1;
      else if (run)  resync <= 1'b0;
      tick <= (run && sel_bit && !slow_clk && !resync && !freq_chg) || step_tick;
    end
  end

  assign bus.slow_clk = slow_clk;
  assign bus.tick     = tick;
  assign bus.freq_num = freq_num;
  assign bus.paused   = (state == PAUSE);

endmodule
